// File: rtl/burst_mem_ctrl_if.sv
// Command, write-data and read-data handshake bundle for burst_mem_ctrl.
// master drives commands and write data; slave is the controller.
interface burst_mem_ctrl_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 3
);
    logic              en;
    logic              rw;
    logic [ADDR_W-1:0] add;
    logic [ADDR_W-1:0] len;
    logic              abort;
    logic [DATA_W-1:0] datain;
    logic              din_valid;
    logic              din_ready;
    logic [DATA_W-1:0] dataout;
    logic              dout_valid;
    logic              dout_ready;
    logic              busy;
    logic              done;

    modport master (
        output en, rw, add, len, abort, datain, din_valid, dout_ready,
        input  din_ready, dataout, dout_valid, busy, done
    );

    modport slave (
        input  en, rw, add, len, abort, datain, din_valid, dout_ready,
        output din_ready, dataout, dout_valid, busy, done
    );
endinterface

// File: rtl/burst_mem_ctrl.sv
// Burst read/write controller over a small register-file memory with
// ready/valid beats, abort and a one-cycle done pulse.
module burst_mem_ctrl #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 3
) (
    input logic             clk,
    input logic             rst_n,
    burst_mem_ctrl_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {StIdle, StWrite, StRead, StDone} state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_len;
    logic [ADDR_W:0]   r_cnt;  // beats accepted (write) or issued (read)
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_dataout;
    logic              r_dout_valid;

    logic              w_start;
    logic              w_abort;
    logic              w_wr_beat;
    logic              w_wr_last;
    logic              w_rd_issue;
    logic              w_rd_last;
    logic [ADDR_W:0]   w_beats;

    assign w_beats    = {1'b0, r_len} + (ADDR_W + 1)'(1);
    assign w_start    = (r_state == StIdle) && bus.en;
    assign w_abort    = bus.abort && ((r_state == StWrite) || (r_state == StRead));
    assign w_wr_beat  = (r_state == StWrite) && bus.din_valid && !bus.abort;
    assign w_wr_last  = w_wr_beat && (r_cnt == {1'b0, r_len});
    assign w_rd_issue = (r_state == StRead) && !bus.abort &&
                        (!r_dout_valid || bus.dout_ready) && (r_cnt < w_beats);
    assign w_rd_last  = (r_state == StRead) && !bus.abort && r_dout_valid &&
                        bus.dout_ready && (r_cnt == w_beats);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (bus.en) w_state_next = bus.rw ? StWrite : StRead;
            StWrite: begin
                if (bus.abort)      w_state_next = StIdle;
                else if (w_wr_last) w_state_next = StDone;
            end
            StRead: begin
                if (bus.abort)      w_state_next = StIdle;
                else if (w_rd_last) w_state_next = StDone;
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        bus.din_ready = (r_state == StWrite);
        bus.busy      = (r_state != StIdle);
        bus.done      = (r_state == StDone);
    end

    assign bus.dataout    = r_dataout;
    assign bus.dout_valid = r_dout_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr        <= '0;
            r_len        <= '0;
            r_cnt        <= '0;
            r_dataout    <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            if (w_start) begin
                r_ptr <= bus.add;
                r_len <= bus.len;
                r_cnt <= '0;
            end
            if (w_wr_beat || w_rd_issue) begin
                r_ptr <= r_ptr + 1'b1;
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_rd_issue) begin
                r_dataout <= r_mem[r_ptr];
            end
            if (w_abort || w_rd_last) begin
                r_dout_valid <= 1'b0;
            end else if (w_rd_issue) begin
                r_dout_valid <= 1'b1;
            end
        end
    end

    // Storage is deliberately left out of reset so contents survive it.
    always_ff @(posedge clk) begin
        if (rst_n && w_wr_beat) begin
            r_mem[r_ptr] <= bus.datain;
        end
    end
endmodule

// File: doc/burst_mem_ctrl.md
BURST_MEM_CTRL -- requirements
Module: burst_mem_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 4, data word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 3, address width; DEPTH = 2**ADDR_W words.
REQ-003 Port clk  input  1  single clock; all logic on rising edge.
REQ-004 Port rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port en  input  1  command strobe; sampled only in IDLE.
REQ-006 Port rw  input  1  command type: 1 = write burst, 0 = read burst.
REQ-007 Port add  input  ADDR_W  burst start address.
REQ-008 Port len  input  ADDR_W  burst length minus one (0 = 1 beat, max DEPTH beats).
REQ-009 Port abort  input  1  terminate current burst.
REQ-010 Port datain  input  DATA_W  write data.
REQ-011 Port din_valid  input  1  write data valid.
REQ-012 Port din_ready  output  1  block accepts write data.
REQ-013 Port dataout  output  DATA_W  registered read data.
REQ-014 Port dout_valid  output  1  dataout valid.
REQ-015 Port dout_ready  input  1  consumer accepts read data.
REQ-016 Port busy  output  1  high in any state other than IDLE.
REQ-017 Port done  output  1  one-cycle pulse on burst completion.

Function
REQ-018 Storage SHALL be DEPTH x DATA_W registers, not reset.
REQ-019 FSM states SHALL be IDLE, WRITE, READ, DONE.
REQ-020 IDLE with en=1 at edge T SHALL capture add, len, rw into internal pointer, count, mode; state at T+1 is WRITE (rw=1) or READ (rw=0).
REQ-021 en, rw, add, len SHALL be ignored outside IDLE.
REQ-022 din_ready SHALL equal 1 exactly when state is WRITE.
REQ-023 In WRITE, each edge with din_valid=1 SHALL store datain at mem[ptr] and increment ptr; cycles with din_valid=0 write nothing.
REQ-024 Pointer SHALL increment modulo DEPTH (DEPTH-1 wraps to 0).
REQ-025 WRITE SHALL go to DONE on the edge accepting beat len+1.
REQ-026 In READ, when dout_valid=0 or dout_ready=1 and beats issued < len+1, the block SHALL load dataout = mem[ptr], set dout_valid=1, increment ptr; first valid data at T+2.
REQ-027 While dout_valid=1 and dout_ready=0, dataout and dout_valid SHALL hold.
REQ-028 READ SHALL go to DONE on the edge the last beat is accepted (dout_valid=1, dout_ready=1); dout_valid clears on that edge.
REQ-029 DONE SHALL last one cycle with done=1, then IDLE.
REQ-030 abort=1 in WRITE or READ SHALL move to IDLE on the next edge, clear dout_valid, write no data that edge, and not pulse done; abort in IDLE or DONE SHALL be ignored.
REQ-031 Abort SHALL take priority over a simultaneous beat.
REQ-032 busy SHALL be 1 in WRITE, READ, DONE.

Reset
REQ-033 rst_n=0 at an edge SHALL force IDLE, dataout=0, dout_valid=0, done=0, din_ready=0, busy=0, ptr=0, count=0, at any state including mid-burst.
REQ-034 Memory contents SHALL be unaffected by reset.

Verification (DATA_W=4, ADDR_W=3)
REQ-035 rst_n=0 for 2 cycles mid-READ -> busy=0, dout_valid=0, dataout=0, din_ready=0 after first reset edge.
REQ-036 Write en=1 rw=1 add=6 len=3, data 1,2,3,4 with din_valid=1 -> mem[6]=1, mem[7]=2, mem[0]=3, mem[1]=4; done pulses one cycle after fourth beat.
REQ-037 Read add=6 len=3, dout_ready=1 -> dataout 1,2,3,4 on consecutive cycles from T+2, then done=1 one cycle, then busy=0.
REQ-038 Same read, dout_ready=0 for 3 cycles while dataout=2 -> dataout=2, dout_valid=1 held; sequence resumes 3,4 with no loss or duplication.
REQ-039 Write len=2 with din_valid pattern 1,0,1,0,1 -> exactly 3 words written at consecutive addresses; done after fifth cycle.
REQ-040 abort=1 after 2 write beats with add=0 len=7 -> IDLE next edge, done stays 0, mem[2..7] unchanged; en asserted during the burst has no effect.
